// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl_if
//  Description : Instruction-memory address/data port, redirect request and
//                decode-side valid/ready handshake of the fetch controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if #(
    parameter int AW         = 10,
    parameter int INST_WIDTH = 32
);
    logic [AW-1:0]         imem_addr_o;
    logic [INST_WIDTH-1:0] imem_inst_i;
    logic                  redirect_i;
    logic [31:0]           redirect_pc_i;
    logic                  inst_valid_o;
    logic [INST_WIDTH-1:0] inst_o;
    logic [31:0]           pc_o;
    logic                  inst_ready_i;
    logic                  halted_o;

    // Fetch controller side
    modport master (
        output imem_addr_o,
        input  imem_inst_i,
        input  redirect_i,
        input  redirect_pc_i,
        output inst_valid_o,
        output inst_o,
        output pc_o,
        input  inst_ready_i,
        output halted_o
    );

    // Memory / decode / branch-unit side
    modport slave (
        input  imem_addr_o,
        output imem_inst_i,
        output redirect_i,
        output redirect_pc_i,
        input  inst_valid_o,
        input  inst_o,
        input  pc_o,
        output inst_ready_i,
        input  halted_o
    );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : RV32I instruction-fetch controller. Owns the PC, drives the
//                combinational instruction memory, buffers {pc, inst} pairs
//                in a small FIFO for decode, handles branch/jump redirects
//                with a flush and halts on an all-zero instruction word.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter int          MEM_SIZE   = 1024,
    parameter int          INST_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  wire          clk_i,
    input  wire          rst_i,
    fetch_ctrl_if.master bus
);

    localparam int AW   = $clog2(MEM_SIZE);
    localparam int c_PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_PW-1:0] c_LAST_PTR = c_PW'(FIFO_DEPTH - 1);
    localparam logic [c_CW-1:0] c_DEPTH    = c_CW'(FIFO_DEPTH);

    localparam logic [0:0] c_ST_RUN  = 1'b0;
    localparam logic [0:0] c_ST_HALT = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic [31:0]           r_pc;

    logic [31:0]           r_fifo_pc   [FIFO_DEPTH];
    logic [INST_WIDTH-1:0] r_fifo_inst [FIFO_DEPTH];
    logic [c_PW-1:0]       r_rd_ptr;
    logic [c_PW-1:0]       r_wr_ptr;
    logic [c_CW-1:0]       r_count;

    // Last head shown, so inst_o/pc_o hold steady while the FIFO is empty
    logic [31:0]           r_last_pc;
    logic [INST_WIDTH-1:0] r_last_inst;

    logic                  w_not_empty;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_space;
    logic                  w_inst_zero;
    logic                  w_fetch;
    logic                  w_push;
    logic                  w_halted;
    logic                  w_unused;

    // Only word-aligned targets are meaningful; the low bits are dropped
    assign w_unused = &{1'b0, bus.redirect_pc_i[1:0]};

    function automatic logic [c_PW-1:0] f_next_ptr(input logic [c_PW-1:0] ptr);
        return (ptr == c_LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    // A redirect hides the head so nothing is consumed in a flush cycle
    assign w_not_empty = (r_count != '0);
    assign w_valid     = w_not_empty & ~bus.redirect_i;
    assign w_pop       = w_valid & bus.inst_ready_i;
    assign w_space     = (r_count < c_DEPTH) | w_pop;
    assign w_inst_zero = (bus.imem_inst_i == '0);

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: redirect always restarts fetch, a zero word halts it
    always_comb begin
        w_state_next = r_state;
        if (bus.redirect_i) begin
            w_state_next = c_ST_RUN;
        end else if (w_fetch && w_inst_zero) begin
            w_state_next = c_ST_HALT;
        end
    end

    // FSM outputs: fetch only in RUN with room and no redirect pending
    always_comb begin
        w_fetch  = 1'b0;
        w_push   = 1'b0;
        w_halted = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                w_fetch = ~bus.redirect_i & w_space;
                w_push  = ~bus.redirect_i & w_space & ~w_inst_zero;
            end
            c_ST_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_halted = 1'b0;
            end
        endcase
    end

    // PC, FIFO pointers/occupancy and held head; redirect flushes everything
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc        <= RESET_PC;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_last_pc   <= '0;
            r_last_inst <= '0;
        end else begin
            if (w_not_empty) begin
                r_last_pc   <= r_fifo_pc[r_rd_ptr];
                r_last_inst <= r_fifo_inst[r_rd_ptr];
            end
            if (bus.redirect_i) begin
                r_pc     <= {bus.redirect_pc_i[31:2], 2'b00};
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_pc     <= r_pc + 32'd4;
                    r_wr_ptr <= f_next_ptr(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= f_next_ptr(r_rd_ptr);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // FIFO storage; contents are only observed while the count covers them
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_pc;
            r_fifo_inst[r_wr_ptr] <= bus.imem_inst_i;
        end
    end

    assign bus.imem_addr_o  = r_pc[AW-1:0];
    assign bus.inst_valid_o = w_valid;
    assign bus.inst_o       = w_not_empty ? r_fifo_inst[r_rd_ptr] : r_last_inst;
    assign bus.pc_o         = w_not_empty ? r_fifo_pc[r_rd_ptr]   : r_last_pc;
    assign bus.halted_o     = w_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_ctrl
//  Description : Directed self-checking bench for fetch_ctrl: reset values,
//                sequential fetch, backpressure, redirects, address wrap and
//                mid-stream reset against hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mem  [256];
    logic [31:0] prog [4];

    fetch_ctrl_if #(.AW(10), .INST_WIDTH(32)) bus ();

    fetch_ctrl #(
        .MEM_SIZE   (1024),
        .INST_WIDTH (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Combinational instruction memory model
    assign bus.imem_inst_i = mem[bus.imem_addr_o[9:2]];

    // Hold reset for one edge, leave the bench at a falling edge with reset low
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.inst_ready_i  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        n_vec++; if (bus.inst_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", bus.inst_valid_o); end
        n_vec++; if (bus.halted_o !== 1'b0) begin n_err++; $display("FAIL rst_halted: got %b expected 0", bus.halted_o); end
        n_vec++; if (bus.inst_o !== 32'h0) begin n_err++; $display("FAIL rst_inst: got %h expected 00000000", bus.inst_o); end
        n_vec++; if (bus.pc_o !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h expected 00000000", bus.pc_o); end
        n_vec++; if (bus.imem_addr_o !== 10'h0) begin n_err++; $display("FAIL rst_addr: got %h expected 000", bus.imem_addr_o); end
        rst = 1'b0; #1;
        n_vec++; if (bus.inst_valid_o !== 1'b0) begin n_err++; $display("FAIL post_rst_valid: got %b expected 0", bus.inst_valid_o); end
        n_vec++; if (bus.imem_addr_o !== 10'h0) begin n_err++; $display("FAIL post_rst_addr: got %h expected 000", bus.imem_addr_o); end
    endtask

    task automatic test_sequential();
        do_reset();
        bus.inst_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            n_vec++; if (bus.inst_valid_o !== 1'b1) begin n_err++; $display("FAIL seq_valid[%0d]: got %b expected 1", k, bus.inst_valid_o); end
            n_vec++; if (bus.pc_o !== 32'(4 * k)) begin n_err++; $display("FAIL seq_pc[%0d]: got %h expected %h", k, bus.pc_o, 32'(4 * k)); end
            n_vec++; if (bus.inst_o !== prog[k]) begin n_err++; $display("FAIL seq_inst[%0d]: got %h expected %h", k, bus.inst_o, prog[k]); end
            n_vec++; if (bus.halted_o !== 1'b0) begin n_err++; $display("FAIL seq_halted[%0d]: got %b expected 0", k, bus.halted_o); end
        end
        @(negedge clk); #1;
        n_vec++; if (bus.halted_o !== 1'b1) begin n_err++; $display("FAIL seq_halt: got %b expected 1", bus.halted_o); end
        n_vec++; if (bus.imem_addr_o !== 10'h010) begin n_err++; $display("FAIL seq_halt_addr: got %h expected 010", bus.imem_addr_o); end
        for (int k = 0; k < 2; k++) begin
            n_vec++; if (bus.inst_valid_o !== 1'b0) begin n_err++; $display("FAIL seq_no_valid[%0d]: got %b expected 0", k, bus.inst_valid_o); end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk); #1;
        @(negedge clk); #1;
        n_vec++; if (bus.imem_addr_o !== 10'h008) begin n_err++; $display("FAIL bp_addr_full: got %h expected 008", bus.imem_addr_o); end
        repeat (3) @(negedge clk);
        #1;
        n_vec++; if (bus.imem_addr_o !== 10'h008) begin n_err++; $display("FAIL bp_addr_stall: got %h expected 008", bus.imem_addr_o); end
        n_vec++; if (bus.inst_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_valid_stall: got %b expected 1", bus.inst_valid_o); end
        n_vec++; if (bus.pc_o !== 32'h0) begin n_err++; $display("FAIL bp_head_stall: got %h expected 00000000", bus.pc_o); end
        bus.inst_ready_i = 1'b1; #1;
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (bus.inst_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b expected 1", k, bus.inst_valid_o); end
            n_vec++; if (bus.pc_o !== 32'(4 * k)) begin n_err++; $display("FAIL bp_pc[%0d]: got %h expected %h", k, bus.pc_o, 32'(4 * k)); end
            n_vec++; if (bus.inst_o !== prog[k]) begin n_err++; $display("FAIL bp_inst[%0d]: got %h expected %h", k, bus.inst_o, prog[k]); end
            @(negedge clk); #1;
        end
        n_vec++; if (bus.inst_valid_o !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %b expected 0", bus.inst_valid_o); end
        n_vec++; if (bus.halted_o !== 1'b1) begin n_err++; $display("FAIL bp_halted: got %b expected 1", bus.halted_o); end
    endtask

    task automatic test_redirect_full();
        do_reset();
        @(negedge clk);
        @(negedge clk); #1;
        n_vec++; if (bus.inst_valid_o !== 1'b1) begin n_err++; $display("FAIL rf_full_valid: got %b expected 1", bus.inst_valid_o); end
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0006;
        bus.inst_ready_i  = 1'b1;
        #1;
        n_vec++; if (bus.inst_valid_o !== 1'b0) begin n_err++; $display("FAIL rf_valid_masked: got %b expected 0", bus.inst_valid_o); end
        @(negedge clk);
        bus.redirect_i = 1'b0; #1;
        n_vec++; if (bus.inst_valid_o !== 1'b0) begin n_err++; $display("FAIL rf_flushed: got %b expected 0", bus.inst_valid_o); end
        n_vec++; if (bus.imem_addr_o !== 10'h004) begin n_err++; $display("FAIL rf_addr: got %h expected 004", bus.imem_addr_o); end
        @(negedge clk); #1;
        n_vec++; if (bus.inst_valid_o !== 1'b1) begin n_err++; $display("FAIL rf_tgt_valid: got %b expected 1", bus.inst_valid_o); end
        n_vec++; if (bus.pc_o !== 32'h4) begin n_err++; $display("FAIL rf_tgt_pc: got %h expected 00000004", bus.pc_o); end
        n_vec++; if (bus.inst_o !== prog[1]) begin n_err++; $display("FAIL rf_tgt_inst: got %h expected %h", bus.inst_o, prog[1]); end
    endtask

    task automatic test_redirect_halt();
        do_reset();
        bus.inst_ready_i = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        n_vec++; if (bus.halted_o !== 1'b1) begin n_err++; $display("FAIL rh_halted: got %b expected 1", bus.halted_o); end
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0008;
        #1;
        n_vec++; if (bus.halted_o !== 1'b1) begin n_err++; $display("FAIL rh_halted_reg: got %b expected 1", bus.halted_o); end
        @(negedge clk);
        bus.redirect_i = 1'b0; #1;
        n_vec++; if (bus.halted_o !== 1'b0) begin n_err++; $display("FAIL rh_unhalted: got %b expected 0", bus.halted_o); end
        n_vec++; if (bus.imem_addr_o !== 10'h008) begin n_err++; $display("FAIL rh_addr: got %h expected 008", bus.imem_addr_o); end
        for (int k = 2; k < 4; k++) begin
            @(negedge clk); #1;
            n_vec++; if (bus.inst_valid_o !== 1'b1) begin n_err++; $display("FAIL rh_valid[%0d]: got %b expected 1", k, bus.inst_valid_o); end
            n_vec++; if (bus.pc_o !== 32'(4 * k)) begin n_err++; $display("FAIL rh_pc[%0d]: got %h expected %h", k, bus.pc_o, 32'(4 * k)); end
            n_vec++; if (bus.inst_o !== prog[k]) begin n_err++; $display("FAIL rh_inst[%0d]: got %h expected %h", k, bus.inst_o, prog[k]); end
        end
        @(negedge clk); #1;
        n_vec++; if (bus.inst_valid_o !== 1'b0) begin n_err++; $display("FAIL rh_end_valid: got %b expected 0", bus.inst_valid_o); end
        n_vec++; if (bus.halted_o !== 1'b1) begin n_err++; $display("FAIL rh_rehalt: got %b expected 1", bus.halted_o); end
        n_vec++; if (bus.imem_addr_o !== 10'h010) begin n_err++; $display("FAIL rh_rehalt_addr: got %h expected 010", bus.imem_addr_o); end
    endtask

    task automatic test_addr_wrap();
        @(negedge clk);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_03FC;
        bus.inst_ready_i  = 1'b1;
        @(negedge clk);
        bus.redirect_i = 1'b0; #1;
        n_vec++; if (bus.imem_addr_o !== 10'h3FC) begin n_err++; $display("FAIL aw_addr_3fc: got %h expected 3fc", bus.imem_addr_o); end
        @(negedge clk); #1;
        n_vec++; if (bus.pc_o !== 32'h3FC) begin n_err++; $display("FAIL aw_pc_3fc: got %h expected 000003fc", bus.pc_o); end
        n_vec++; if (bus.inst_o !== 32'h0000_0013) begin n_err++; $display("FAIL aw_inst_3fc: got %h expected 00000013", bus.inst_o); end
        n_vec++; if (bus.imem_addr_o !== 10'h000) begin n_err++; $display("FAIL aw_addr_inc_wrap: got %h expected 000", bus.imem_addr_o); end
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0400;
        #1;
        n_vec++; if (bus.inst_valid_o !== 1'b0) begin n_err++; $display("FAIL aw_valid_masked: got %b expected 0", bus.inst_valid_o); end
        @(negedge clk);
        bus.redirect_i = 1'b0; #1;
        n_vec++; if (bus.imem_addr_o !== 10'h000) begin n_err++; $display("FAIL aw_addr_400: got %h expected 000", bus.imem_addr_o); end
        @(negedge clk); #1;
        n_vec++; if (bus.inst_valid_o !== 1'b1) begin n_err++; $display("FAIL aw_valid_400: got %b expected 1", bus.inst_valid_o); end
        n_vec++; if (bus.pc_o !== 32'h400) begin n_err++; $display("FAIL aw_pc_400: got %h expected 00000400", bus.pc_o); end
        n_vec++; if (bus.inst_o !== prog[0]) begin n_err++; $display("FAIL aw_inst_400: got %h expected %h", bus.inst_o, prog[0]); end
    endtask

    task automatic test_midstream_reset();
        @(negedge clk);
        bus.inst_ready_i  = 1'b0;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0;
        @(negedge clk);
        bus.redirect_i = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        n_vec++; if (bus.imem_addr_o !== 10'h008) begin n_err++; $display("FAIL mr_two_entries: got %h expected 008", bus.imem_addr_o); end
        rst               = 1'b1;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0008;
        @(negedge clk);
        rst            = 1'b0;
        bus.redirect_i = 1'b0;
        #1;
        n_vec++; if (bus.inst_valid_o !== 1'b0) begin n_err++; $display("FAIL mr_valid: got %b expected 0", bus.inst_valid_o); end
        n_vec++; if (bus.imem_addr_o !== 10'h000) begin n_err++; $display("FAIL mr_addr: got %h expected 000", bus.imem_addr_o); end
        n_vec++; if (bus.pc_o !== 32'h0) begin n_err++; $display("FAIL mr_pc_clear: got %h expected 00000000", bus.pc_o); end
        bus.inst_ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            n_vec++; if (bus.inst_valid_o !== 1'b1) begin n_err++; $display("FAIL mr_valid[%0d]: got %b expected 1", k, bus.inst_valid_o); end
            n_vec++; if (bus.pc_o !== 32'(4 * k)) begin n_err++; $display("FAIL mr_pc[%0d]: got %h expected %h", k, bus.pc_o, 32'(4 * k)); end
            n_vec++; if (bus.inst_o !== prog[k]) begin n_err++; $display("FAIL mr_inst[%0d]: got %h expected %h", k, bus.inst_o, prog[k]); end
        end
    endtask

    // Upper bound on run time so the bench can never hang
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded 100000 ns");
        $fatal(1, "watchdog expired");
    end

    // Test sequence
    initial begin
        rst               = 1'b1;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.inst_ready_i  = 1'b0;
        prog[0] = 32'h0010_8113;
        prog[1] = 32'h0010_8193;
        prog[2] = 32'h0031_0233;
        prog[3] = 32'hfe21_8ae3;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < 4; i++) mem[i] = prog[i];
        mem[255] = 32'h0000_0013;

        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_full();
        test_redirect_halt();
        test_addr_wrap();
        test_midstream_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
